pio_clkdiv_frac: RTL and testbench
==================================

# pio_clkdiv_frac

Multi-channel fractional clock-enable generator for the PIO block. Each channel divides the system clock by an INT.FRAC divisor, default 16.8. It produces a one-cycle `tick` strobe that gates a state machine, plus an approximately 50 % duty `pclk` for debug and pin output. Divisor changes take effect glitch-free at period boundaries. A per-channel synchronous restart lets software phase-align several state machines.

## Interface
Parameters:
- `NCH`, 4: number of independent channels (one per state machine).
- `INT_W`, 16: integer divisor width.
- `FRAC_W`, 8: fractional divisor width.

Ports:
- `clk` input, 1 bit: system clock; the only clock.
- `reset` input, 1 bit: synchronous, active-high reset.
- `en` input, `NCH` bits: per-channel run enable.
- `restart` input, `NCH` bits: per-channel synchronous phase restart, one-cycle pulse.
- `div_int` input, `NCH*INT_W` bits: integer part of the divisor. Channel i uses bits `[i*INT_W +: INT_W]`. The value 0 means 2^INT_W.
- `div_frac` input, `NCH*FRAC_W` bits: fractional part of the divisor, in units of 2^-FRAC_W.
- `tick` output, `NCH` bits: clock-enable strobe. It is high for one cycle per divided period.
- `pclk` output, `NCH` bits: registered divided clock, high for the first half of each period.

## Operation
Per-channel state:
- `cnt`: down-counter, INT_W+1 bits.
- `facc`: fractional accumulator, FRAC_W bits.
- `plen`: length of the current period, INT_W+1 bits.
- `pclk`: output register.

Definitions:
- `ieff = (div_int==0) ? 2^INT_W : div_int`.
- `tick[i] = en[i] & (cnt==0) & ~restart[i]`. This is a combinational decode of registered state.

Priority per cycle is `reset` > `restart` > `en`.
- `reset`: every channel goes to `cnt=0`, `facc=0`, `plen=1`, `pclk=0`. After reset all `tick` outputs are 0 until `en` is high.
- `restart[i]`: `cnt=0`, `facc=0`, `plen=1`, `pclk=0`. If `en[i]` is high the next cycle, `tick[i]` fires that cycle.
- `en[i]` low: `cnt`, `facc`, `plen` and `pclk` hold. `tick` is 0. Re-enabling resumes mid-period with no lost or extra tick.
- `en[i]` high and `cnt==0` (reload):
  - `{carry, facc} <= facc + div_frac`, computed FRAC_W+1 bits wide.
  - `plen <= ieff + carry`.
  - `cnt <= ieff + carry - 1`.
- `en[i]` high and `cnt!=0`: `cnt <= cnt - 1`.
- `pclk` update on every enabled cycle: `pclk <= (cnt_next >= (plen_next >> 1))`, where `cnt_next` and `plen_next` are the values being written this cycle.
  - Period 1 gives `pclk` constantly 1.
  - Period 2 gives high 1 cycle, low 1 cycle.
  - Period 3 gives high 2 cycles, low 1 cycle.
- The average tick period is exactly `ieff + div_frac/2^FRAC_W`. The instantaneous period is `ieff` or `ieff+1`.
- `div_int` and `div_frac` are sampled only at reload. A mid-period change never shortens or lengthens the current period.
- A divisor of `div_int=1`, `div_frac=0` gives a tick every enabled cycle.
- `div_int=1` with `div_frac` nonzero is legal: periods are 1 or 2.
- Channels are fully independent. Asserting `restart` on several channels in the same cycle aligns their ticks exactly when their divisors are equal.

## Timing
- Zero-latency `tick`: it is derived from the registered `cnt`, with no input-to-output combinational path except through `en` and `restart`.
- `pclk` has one register stage. It changes on the cycle after the state that determines it.
- First tick after reset or restart: the first cycle with `en` high after the restart cycle.
- Counter wrap: `cnt` never underflows, because the reload path is taken at 0. `facc` wraps modulo 2^FRAC_W, and the carry-out adds exactly one cycle.
- Critical path: FRAC_W-bit add feeding an (INT_W+1)-bit add/compare. It must meet the PIO system clock with no pipelining.

## Structure
- Package `pio_clkdiv_pkg`:
  - default `INT_W` and `FRAC_W` constants;
  - `function eff_int(div_int)` implementing the 0→2^INT_W rule.
- Sub-module `pio_clkdiv_chan`: one channel, holding `cnt`, `facc`, `plen` and `pclk`.
- `pio_clkdiv_frac` instantiates `NCH` copies of `pio_clkdiv_chan` in a generate loop and slices the packed buses.

## Test plan
- Divisor 1.0 (`div_int=1`, `div_frac=0`), `en=1`: `tick` high every cycle and `pclk` held at 1.
- Divisor 4.0: `tick` every 4th cycle. `pclk` pattern is 1,1,0,0 repeating, 2 high and 2 low.
- Divisor 2.5 (`div_int=2`, `div_frac=128`) from restart: periods 2,3,2,3,…. Exactly 10 ticks in 25 cycles. `facc` returns to 0 every 2 ticks.
- `INT_W=4`, `div_int=0`, `div_frac=0`: period 16, and `plen` reads 16.
- `div_int` changed from 8 to 3 at cycle 2 of a period: the current period completes at 8 and the following periods are 3. `en` dropped for 5 cycles mid-period: the tick is delayed by exactly 5 cycles.
- Channels 0–3 with equal divisor 5.25 run out of phase, then `restart` is asserted on all four in one cycle: `tick[3:0]` identical thereafter. `reset` asserted mid-period: next cycle `tick=0` and `pclk=0` on all channels.

Source files
------------

// File: rtl/pio_clkdiv_pkg.sv
// Shared constants and helpers for the PIO fractional clock-enable generator.
// The divisor integer field uses 0 to encode the largest period, 2^INT_W.
package pio_clkdiv_pkg;

  localparam int unsigned INT_W_DEF  = 16;
  localparam int unsigned FRAC_W_DEF = 8;

  // Effective integer divisor: a zero field stands for 2^int_w.
  function automatic logic [31:0] eff_int(input logic [31:0] div_int,
                                          input int unsigned int_w = INT_W_DEF);
    return (div_int == 32'd0) ? (32'd1 << int_w) : div_int;
  endfunction

endpackage

// File: rtl/pio_clkdiv_chan.sv
// One fractional divider channel: a down-counter reloaded from INT.FRAC,
// with a tick strobe decoded from registered state and a registered pclk.
module pio_clkdiv_chan
  import pio_clkdiv_pkg::*;
#(
  parameter int unsigned INT_W  = INT_W_DEF,
  parameter int unsigned FRAC_W = FRAC_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              restart,
  input  logic [INT_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  output logic              tick,
  output logic              pclk
);

  localparam int unsigned IW1 = INT_W + 1;

  logic [IW1-1:0]    cnt_q, cnt_d;
  logic [IW1-1:0]    plen_q, plen_d;
  logic [FRAC_W-1:0] facc_q, facc_d;
  logic              pclk_q, pclk_d;

  logic [FRAC_W:0]   fsum;
  logic [IW1-1:0]    ieff;
  logic [IW1-1:0]    reload_len;

  // Reload-path arithmetic is always evaluated; it is only consumed at cnt==0.
  always_comb begin
    fsum       = {1'b0, facc_q} + {1'b0, div_frac};
    ieff       = IW1'(eff_int(32'(div_int), INT_W));
    reload_len = ieff + IW1'(fsum[FRAC_W]);
  end

  always_comb begin
    cnt_d  = cnt_q;
    plen_d = plen_q;
    facc_d = facc_q;
    pclk_d = pclk_q;
    if (restart) begin
      cnt_d  = '0;
      plen_d = IW1'(1);
      facc_d = '0;
      pclk_d = 1'b0;
    end else if (en) begin
      if (cnt_q == '0) begin
        facc_d = fsum[FRAC_W-1:0];
        plen_d = reload_len;
        cnt_d  = reload_len - IW1'(1);
      end else begin
        cnt_d  = cnt_q - IW1'(1);
      end
      // High while the remaining count is in the upper half of the period,
      // which gives ceil(plen/2) high cycles.
      pclk_d = (cnt_d >= (plen_d >> 1));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      plen_q <= IW1'(1);
      facc_q <= '0;
      pclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      plen_q <= plen_d;
      facc_q <= facc_d;
      pclk_q <= pclk_d;
    end
  end

  assign tick = en & (cnt_q == '0) & ~restart;
  assign pclk = pclk_q;

endmodule

// File: rtl/pio_clkdiv_frac.sv
// Multi-channel fractional clock-enable generator: NCH independent dividers,
// each producing a one-cycle tick and a ~50% duty pclk.
module pio_clkdiv_frac
  import pio_clkdiv_pkg::*;
#(
  parameter int unsigned NCH    = 4,
  parameter int unsigned INT_W  = INT_W_DEF,
  parameter int unsigned FRAC_W = FRAC_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NCH-1:0]        en,
  input  logic [NCH-1:0]        restart,
  input  logic [NCH*INT_W-1:0]  div_int,
  input  logic [NCH*FRAC_W-1:0] div_frac,
  output logic [NCH-1:0]        tick,
  output logic [NCH-1:0]        pclk
);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    pio_clkdiv_chan #(
      .INT_W  (INT_W),
      .FRAC_W (FRAC_W)
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .en       (en[i]),
      .restart  (restart[i]),
      .div_int  (div_int[i*INT_W +: INT_W]),
      .div_frac (div_frac[i*FRAC_W +: FRAC_W]),
      .tick     (tick[i]),
      .pclk     (pclk[i])
    );
  end

endmodule

// File: tb/tb_pio_clkdiv_frac.sv
// Randomized and directed bench for pio_clkdiv_frac against a period-level
// reference model (period lengths from INT.FRAC, pclk high for ceil(P/2)).
module tb_pio_clkdiv_frac;

  localparam int NCH = 4, IW = 16, FW = 8, SIW = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic [NCH-1:0]      en, restart, tick, pclk;
  logic [NCH*IW-1:0]   div_int;
  logic [NCH*FW-1:0]   div_frac;
  logic [0:0]          s_en, s_restart, s_tick, s_pclk;
  logic [SIW-1:0]      s_div_int;
  logic [FW-1:0]       s_div_frac;

  pio_clkdiv_frac #(.NCH(NCH), .INT_W(IW), .FRAC_W(FW)) u_dut (
    .clk(clk), .reset(reset), .en(en), .restart(restart),
    .div_int(div_int), .div_frac(div_frac), .tick(tick), .pclk(pclk));

  pio_clkdiv_frac #(.NCH(1), .INT_W(SIW), .FRAC_W(FW)) u_small (
    .clk(clk), .reset(reset), .en(s_en), .restart(s_restart),
    .div_int(s_div_int), .div_frac(s_div_frac), .tick(s_tick), .pclk(s_pclk));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // Model state per channel (index 4 is the small instance): enabled cycles
  // left before the next tick, fractional residue, period length, position.
  int m_rem[5] = '{default: 0};
  int m_acc[5] = '{default: 0};
  int m_p[5]   = '{default: 1};
  int m_j[5]   = '{default: 0};
  bit m_pclk[5] = '{default: 1'b0};
  int ntick[5];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic mstep(input int c, input bit e, input bit r, input int di,
                       input int df, input int iw);
    if (reset || r) begin
      m_rem[c] = 0; m_acc[c] = 0; m_p[c] = 1; m_j[c] = 0; m_pclk[c] = 1'b0;
    end else if (e) begin
      if (m_rem[c] == 0) begin
        int ie, s;
        ie = (di == 0) ? (1 << iw) : di;
        s  = m_acc[c] + df;
        m_p[c]   = ie + s / (1 << FW);
        m_acc[c] = s % (1 << FW);
        m_rem[c] = m_p[c] - 1;
        m_j[c]   = 0;
      end else begin
        m_rem[c]--;
        m_j[c]++;
      end
      m_pclk[c] = (m_j[c] < m_p[c] - m_p[c] / 2);
    end
  endtask

  task automatic cyc();
    logic [NCH-1:0] et, ep;
    #1;
    for (int c = 0; c < NCH; c++) begin
      et[c] = en[c] && !restart[c] && (m_rem[c] == 0);
      ep[c] = m_pclk[c];
    end
    chk("tick", 64'(tick), 64'(et));
    chk("pclk", 64'(pclk), 64'(ep));
    chk("s_tick", 64'(s_tick), 64'(s_en[0] && !s_restart[0] && (m_rem[4] == 0)));
    chk("s_pclk", 64'(s_pclk), 64'(m_pclk[4]));
    for (int c = 0; c < NCH; c++) if (tick[c]) ntick[c]++;
    if (s_tick[0]) ntick[4]++;
    for (int c = 0; c < NCH; c++)
      mstep(c, en[c], restart[c], int'(div_int[c*IW +: IW]), int'(div_frac[c*FW +: FW]), IW);
    mstep(4, s_en[0], s_restart[0], int'(s_div_int), int'(s_div_frac), SIW);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic clr();
    for (int c = 0; c < 5; c++) ntick[c] = 0;
  endtask

  task automatic set_div(input int c, input int di, input int df);
    div_int[c*IW +: IW]  = IW'(di);
    div_frac[c*FW +: FW] = FW'(df);
  endtask

  initial begin
    reset = 1'b1; en = '0; restart = '0; div_int = '0; div_frac = '0;
    s_en = '0; s_restart = '0; s_div_int = '0; s_div_frac = '0;
    for (int c = 0; c < NCH; c++) set_div(c, 16, 128);
    @(negedge clk);
    run(3);
    reset = 1'b0;
    run(2);
    chk("post_rst_tick", 64'(tick), 64'd0);

    // 1.0, 4.0, 2.5 and 5.25 from a common restart
    set_div(0, 1, 0); set_div(1, 4, 0); set_div(2, 2, 128); set_div(3, 5, 64);
    en = '1; restart = '1; run(1); restart = '0;
    clr(); run(25);
    chk("div1_ticks", 64'(ntick[0]), 64'd25);
    chk("div4_ticks", 64'(ntick[1]), 64'd7);
    chk("div2p5_ticks", 64'(ntick[2]), 64'd10);
    chk("div2p5_facc", 64'(u_dut.g_ch[2].u_chan.facc_q), 64'd0);

    // divisor change mid-period: current 8-cycle period completes
    en = 4'b0010; set_div(1, 8, 0); restart = 4'b0010; run(1); restart = '0;
    clr(); run(2); set_div(1, 3, 0); run(6);
    chk("chg_pre", 64'(ntick[1]), 64'd1);
    run(1);
    chk("chg_at8", 64'(ntick[1]), 64'd2);
    run(3);
    chk("chg_at11", 64'(ntick[1]), 64'd3);

    // enable dropped for 5 cycles delays the tick by exactly 5
    set_div(1, 4, 0); restart = 4'b0010; run(1); restart = '0;
    clr(); run(2); en[1] = 1'b0; run(5); en[1] = 1'b1; run(2);
    chk("endrop_pre", 64'(ntick[1]), 64'd1);
    run(1);
    chk("endrop_tick", 64'(ntick[1]), 64'd2);

    // small instance: div_int 0 means 2^4
    s_en = 1'b1; s_div_int = '0; s_div_frac = '0; s_restart = 1'b1; run(1); s_restart = 1'b0;
    clr(); run(40);
    chk("int0_ticks", 64'(ntick[4]), 64'd3);
    chk("int0_plen", 64'(u_small.g_ch[0].u_chan.plen_q), 64'd16);

    // 5.25 on all channels, scrambled phases, then a common restart
    for (int c = 0; c < NCH; c++) set_div(c, 5, 64);
    for (int k = 0; k < 30; k++) begin
      en = NCH'($urandom);
      restart = NCH'($urandom) & NCH'($urandom);
      run(1);
    end
    en = '1; restart = '1; run(1); restart = '0;
    clr(); run(40);
    for (int c = 0; c < NCH; c++) chk($sformatf("align%0d", c), 64'(ntick[c]), 64'd8);

    // reset mid-period
    run(3);
    reset = 1'b1; en = '0; run(1); reset = 1'b0;
    #1;
    chk("rst_mid_tick", 64'(tick), 64'd0);
    chk("rst_mid_pclk", 64'(pclk), 64'd0);
    run(1);

    // randomized traffic
    for (int c = 0; c < NCH; c++) set_div(c, $urandom_range(1, 9), $urandom_range(0, 255));
    for (int k = 0; k < 600; k++) begin
      en = '0; restart = '0;
      for (int c = 0; c < NCH; c++) begin
        en[c] = ($urandom_range(0, 3) != 0);
        restart[c] = ($urandom_range(0, 31) == 0);
        if ($urandom_range(0, 15) == 0)
          set_div(c, $urandom_range(1, 9), $urandom_range(0, 255));
      end
      s_en = 1'($urandom_range(0, 3) != 0);
      s_restart = 1'($urandom_range(0, 47) == 0);
      if ($urandom_range(0, 15) == 0) begin
        s_div_int = SIW'($urandom);
        s_div_frac = FW'($urandom);
      end
      reset = ($urandom_range(0, 199) == 0);
      run(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
